// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE/EXEC/DONE sequencing with one op per 3 cycles.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req0_ack,
  output logic              req1_ack,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic              id_r;
  logic              any_req_s;
  logic              grant_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;
  logic [OP_W-1:0]   sel_op_s;

`ifdef ALU_ARB_RR_EN
  logic              ptr_r;
`endif

  // Arbitration: pick the winning requester and mux its operands.
  always_comb begin
    any_req_s = req0_valid | req1_valid;
    grant_s   = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant_s = ptr_r;
`else
      grant_s = 1'b0;
`endif
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
  end

  // Sequencer: accept in IDLE, let the ALU settle in EXEC, present the response in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      id_r       <= 1'b0;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      alu_a      <= {DATA_W{1'b0}};
      alu_b      <= {DATA_W{1'b0}};
      alu_op     <= {OP_W{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_result <= {DATA_W{1'b0}};
      rsp_flags  <= 4'b0000;
      rsp_id     <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_r      <= 1'b0;
`endif
    end else begin
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r  <= ST_EXEC;
            busy     <= 1'b1;
            alu_a    <= sel_a_s;
            alu_b    <= sel_b_s;
            alu_op   <= sel_op_s;
            id_r     <= grant_s;
            req0_ack <= ~grant_s;
            req1_ack <= grant_s;
`ifdef ALU_ARB_RR_EN
            ptr_r    <= ~grant_s;
`endif
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_EXEC: begin
          // Latched operands have been on the ALU for a full cycle; capture its output as-is.
          state_r    <= ST_DONE;
          rsp_valid  <= 1'b1;
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_id     <= id_r;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU feeds the DUT, a reference model predicts responses.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_ack, req1_ack;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op, alu_flags;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_id;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req0_ack(req0_ack), .req1_ack(req1_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_id(rsp_id), .busy(busy)
  );

  // Reference ALU: returns {C,N,Z,V,result}.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1:  begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  r = a << b[4:0];
      4'd7:  r = a >> b[4:0];
      4'd8:  r = $signed(a) >>> b[4:0];
      4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = ~(a | b);
      4'd12: r = b;
      4'd13: begin w = {1'b0, a} + 33'd1; r = w[31:0]; c = w[32]; end
      default: r = 32'd0;
    endcase
    return {c, r[31], (r == 32'd0), v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_op);

  // Drives one request from a single requester and reports when ack and response were seen.
  task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        output int ack_cyc, output int rsp_cyc, output logic [31:0] res,
                        output logic [3:0] fl, output logic rid, output bit tmo);
    tmo = 1'b0; ack_cyc = -1; rsp_cyc = -1; res = 32'd0; fl = 4'd0; rid = 1'b0;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if ((id == 1'b0 && req0_ack) || (id == 1'b1 && req1_ack)) begin
        ack_cyc = cyc;
        break;
      end
    end
    // Operands change right after acceptance; the in-flight op must not see this.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hFFFF_FFFF; req1_a = 32'hFFFF_FFFF;
    req0_b = ~b; req1_b = ~b; req0_op = ~op; req1_op = ~op;
    if (ack_cyc < 0) begin
      tmo = 1'b1;
      return;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        rsp_cyc = cyc; res = rsp_result; fl = rsp_flags; rid = rsp_id;
        break;
      end
    end
    if (rsp_cyc < 0) tmo = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req0_ack, req1_ack, rsp_valid, busy, rsp_id, rsp_flags} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0", {req0_ack, req1_ack, rsp_valid, busy, rsp_id, rsp_flags});
    end
    vectors++;
    if ({rsp_result, alu_a, alu_b, alu_op} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_data got rsp=%h a=%h b=%h op=%h exp 0", rsp_result, alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_op();
    int ack_c, rsp_c, rel;
    logic [31:0] res; logic [3:0] fl; logic rid; bit tmo;
    rel = cyc;
    run_op(1'b0, 32'd3, 32'd5, 4'd0, ack_c, rsp_c, res, fl, rid, tmo);
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL single_timeout got timeout exp response"); end
    vectors++;
    if (ack_c !== rel + 1) begin miscompares++; $display("FAIL first_ack_cycle got %0d exp %0d", ack_c, rel + 1); end
    // Ack is visible in EXEC, the response in DONE one edge later.
    vectors++;
    if (rsp_c !== ack_c + 1) begin miscompares++; $display("FAIL single_latency got %0d exp %0d", rsp_c - ack_c, 1); end
    vectors++;
    if ({rid, fl, res} !== {1'b0, 4'b0000, 32'd8}) begin
      miscompares++; $display("FAIL single_add got id=%0d fl=%b res=%0d exp id=0 fl=0000 res=8", rid, fl, res);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL single_pulse got rsp_valid=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_opcode_sweep();
    int ack_c, rsp_c, prev;
    logic [31:0] res; logic [3:0] fl; logic rid; bit tmo;
    logic [35:0] exp;
    prev = -1;
    for (int op = 0; op < 14; op++) begin
      run_op(1'b1, 32'd3, 32'd5, op[3:0], ack_c, rsp_c, res, fl, rid, tmo);
      exp = alu_model(32'd3, 32'd5, op[3:0]);
      vectors++;
      if (tmo || {rid, fl, res} !== {1'b1, exp}) begin
        miscompares++;
        $display("FAIL sweep op=%0d got tmo=%0d id=%0d fl=%b res=%h exp id=1 fl=%b res=%h", op, tmo, rid, fl, res, exp[35:32], exp[31:0]);
      end
      if (prev >= 0) begin
        vectors++;
        if (ack_c !== prev + 3) begin miscompares++; $display("FAIL sweep_spacing op=%0d got %0d exp 3", op, ack_c - prev); end
      end
      prev = ack_c;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change();
    int ack_c, rsp_c;
    logic [31:0] res; logic [3:0] fl; logic rid; bit tmo;
    run_op(1'b0, 32'd3, 32'd7, 4'd0, ack_c, rsp_c, res, fl, rid, tmo);
    vectors++;
    if (tmo || res !== 32'd10) begin miscompares++; $display("FAIL operand_change got tmo=%0d res=%h exp 0000000a", tmo, res); end
    @(posedge clk); #1;
    vectors++;
    if ({alu_a, alu_b, alu_op} !== {32'd3, 32'd7, 4'd0}) begin
      miscompares++; $display("FAIL alu_hold got a=%h b=%h op=%h exp 3 7 0", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_random();
    int ack_c, rsp_c;
    logic [31:0] res, a, b; logic [3:0] fl, op; logic rid, id; bit tmo;
    logic [35:0] exp;
    for (int n = 0; n < 20; n++) begin
      id = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      op = 4'($urandom_range(0, 13));
      if (n % 4 == 0) b = a;
      run_op(id, a, b, op, ack_c, rsp_c, res, fl, rid, tmo);
      exp = alu_model(a, b, op);
      vectors++;
      if (tmo || {rid, fl, res} !== {id, exp}) begin
        miscompares++;
        $display("FAIL random n=%0d got tmo=%0d id=%0d fl=%b res=%h exp id=%0d fl=%b res=%h", n, tmo, rid, fl, res, id, exp[35:32], exp[31:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_window();
    int ack0, ack1;
    bit early;
    ack0 = -1; ack1 = -1; early = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd6; req0_op = 4'd1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (req0_ack) begin ack0 = cyc; break; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_op = 4'd4;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (req1_ack) begin ack1 = cyc; break; end
      if (busy === 1'b0 && i > 2) early = 1'b1;
    end
    req1_valid = 1'b0;
    vectors++;
    if (ack0 < 0 || ack1 !== ack0 + 3 || early) begin
      miscompares++; $display("FAIL busy_window got ack0=%0d ack1=%0d exp ack1=ack0+3", ack0, ack1);
    end
    repeat (3) @(posedge clk);
    #1;
    // A valid withdrawn while the block is busy must vanish without an ack.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'd0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (req1_ack) early = 1'b1;
    end
    vectors++;
    if (early) begin miscompares++; $display("FAIL discard got req1_ack exp none"); end
  endtask

  task automatic test_reset_exec();
    int ack_c, rsp_c;
    logic [31:0] res; logic [3:0] fl; logic rid; bit tmo, seen;
    ack_c = -1; seen = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_op = 4'd1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (req0_ack) begin ack_c = cyc; break; end
    end
    req0_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ack_c < 0 || {busy, rsp_valid, req0_ack, req1_ack, rsp_result, alu_a, alu_b, alu_op} !== 104'd0) begin
      miscompares++;
      $display("FAIL reset_exec got ack=%0d busy=%b rv=%b a=%h b=%h op=%h exp all 0", ack_c, busy, rsp_valid, alu_a, alu_b, alu_op);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL reset_abort got rsp_valid exp none"); end
    run_op(1'b1, 32'd40, 32'd2, 4'd0, ack_c, rsp_c, res, fl, rid, tmo);
    vectors++;
    if (tmo || {rid, res} !== {1'b1, 32'd42}) begin
      miscompares++; $display("FAIL after_reset got tmo=%0d id=%0d res=%0d exp id=1 res=42", tmo, rid, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int order[$];
    int exp_order[$];
    int last, ptr;
    logic [35:0] exp;
    bit both;
    both = 1'b0; last = -1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    // Reference arbitration: round-robin favours the pointer and hands it to the loser.
    ptr = 0;
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_RR_EN
      exp_order.push_back(ptr);
      ptr = 1 - ptr;
`else
      exp_order.push_back(0);
`endif
    end
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23; req0_op = 4'd0;
    req1_valid = 1'b1; req1_a = 32'd50;  req1_b = 32'd8;  req1_op = 4'd1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (req0_ack && req1_ack) both = 1'b1;
      if (req0_ack) begin order.push_back(0); last = 0; end
      if (req1_ack) begin order.push_back(1); last = 1; end
      if (order.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (rsp_valid) begin
        exp = (last == 0) ? alu_model(32'd100, 32'd23, 4'd0) : alu_model(32'd50, 32'd8, 4'd1);
        vectors++;
        if ({rsp_id, rsp_flags, rsp_result} !== {last[0], exp}) begin
          miscompares++;
          $display("FAIL contention_rsp got id=%0d res=%h exp id=%0d res=%h", rsp_id, rsp_result, last, exp[31:0]);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    vectors++;
    if (both || order.size() != 4 || order != exp_order) begin
      miscompares++;
      $display("FAIL contention_order got %p exp %p", order, exp_order);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_opcode_sweep();
    test_operand_change();
    test_random();
    test_busy_window();
    test_reset_exec();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit exp finish");
    $fatal(1);
  end

endmodule
